swerve_angle_scheduler: RTL
===========================

Name: swerve_angle_scheduler

Overview:
- Time-shares one angle_to_pwm engine (and its downstream pwm) among NUM_WHEELS steering requesters.
- Picks a requester round-robin and muxes that requester's target and live encoder angle into the engine.
- Issues the one-cycle angle_update pulse, then waits for angle_done, startup_fail or a timeout.
- Returns a per-wheel done or fail pulse. Sits between the drive-command register block and the steering motor path.

Parameters:
- NUM_WHEELS, 4, number of requesters (2..8).
- ANGLE_W, 12, angle width in encoder counts.
- TIMEOUT_CYCLES, 2000000, maximum WAIT duration before a forced abort.
- SETTLE_CYCLES, 16, idle gap after abort or fail before the next grant.
- DEADBAND, 2, skip threshold in counts (used only with the optional feature).

Ports:
- clock  in  1  main clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_WHEELS  level request per wheel, held until that wheel's done or fail pulse
- req_angle  in  NUM_WHEELS*ANGLE_W  flattened target angles; wheel i occupies [i*ANGLE_W +: ANGLE_W]
- enc_angle  in  NUM_WHEELS*ANGLE_W  flattened live encoder angles, same packing
- target_angle  out  ANGLE_W  to engine
- current_angle  out  ANGLE_W  to engine
- angle_update  out  1  to engine, one-cycle pulse
- abort_angle  out  1  to engine, one-cycle pulse
- angle_done  in  1  from engine
- startup_fail  in  1  from engine
- wheel_done  out  NUM_WHEELS  one-cycle success pulse per wheel
- wheel_fail  out  NUM_WHEELS  one-cycle failure pulse per wheel
- busy  out  1  high in any state except IDLE
- active_idx  out  3  index of the granted wheel; valid while busy

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer = 0; timeout counter = 0.
  - Reset mid-operation drops the grant with no abort pulse; the engine has its own reset.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_WHEELS.
  - Latch the index into active_idx and the target into target_angle; go to ISSUE.
  - Request-to-grant latency is 1 cycle.
- ISSUE (1 cycle): angle_update=1, counter cleared, go to WAIT.
- current_angle is a registered mux of enc_angle[active_idx], updated every cycle while busy, so it lags the encoder by 1 cycle.
- WAIT: counter increments each cycle. Exits, evaluated in this priority order:
  1. angle_done=1: pulse wheel_done[active_idx] next cycle, then IDLE.
  2. startup_fail=1: pulse wheel_fail[active_idx]; abort_angle=1 for 1 cycle; go to SETTLE.
  3. req[active_idx] deasserted: abort_angle=1 for 1 cycle; no done or fail pulse; go to SETTLE.
  4. Counter reaches TIMEOUT_CYCLES-1: abort_angle=1 and wheel_fail pulse; go to SETTLE.
- If angle_done and startup_fail arrive in the same cycle, done wins.
- SETTLE: count SETTLE_CYCLES with all engine outputs idle, then go to IDLE.
- On every exit to IDLE, the pointer becomes (active_idx+1) mod NUM_WHEELS. No requester can starve; worst-case wait is (NUM_WHEELS-1) service times.
- req_angle changes after the grant are ignored until the next grant.
- angle_update and abort_angle are never high in the same cycle.

Optional Feature:
- Macro: SWERVE_SCHED_DEADBAND_EN.
- Enabled:
  - In ISSUE, compute d = (target - enc) mod 2^ANGLE_W and dist = min(d, 2^ANGLE_W - d).
  - If dist <= DEADBAND: no angle_update, pulse wheel_done the next cycle, return to IDLE and advance the pointer.
- Disabled: every grant issues angle_update.

Decomposition:
- Package swerve_sched_pkg holds:
  - The state enum: IDLE, ISSUE, WAIT, SETTLE, FINISH.
  - Width constants and the index width function clog2(NUM_WHEELS).
- Sub-module rr_arbiter:
  - Inputs: req vector and pointer. Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single grant: req=4'b0001, req_angle[0]=100, enc[0]=10.
  - Expect angle_update 1 cycle after req, target_angle=100.
  - Engine angle_done drives wheel_done[0] the next cycle; busy drops.
- Round-robin: req=4'b1011 held, each wheel completed in turn.
  - Expect grant order 0,1,3,0 and the pointer wrapping correctly.
- Stall: engine startup_fail during WAIT on wheel 2.
  - Expect wheel_fail[2], one abort_angle pulse, 16 SETTLE cycles, then the next grant.
- Timeout: TIMEOUT_CYCLES=50 and angle_done never asserts.
  - Expect abort_angle exactly at cycle 50 of WAIT, plus wheel_fail.
- Withdrawal and reset:
  - Drop req[1] mid-WAIT: expect abort only, no done or fail pulse.
  - Assert reset mid-WAIT: all outputs 0 the next cycle.
- Deadband (macro on): target=4095, enc=1, so dist=2.
  - Expect no angle_update and wheel_done 2 cycles after req.
  - With target=4092 (dist 5), expect a normal ISSUE.

Source files
------------

// File: rtl/swerve_angle_scheduler_pkg.sv
// Shared definitions for swerve_angle_scheduler: scheduler state encoding and
// width helpers used by the top level and the round-robin arbiter.
package swerve_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SETTLE,
        FINISH
    } sched_state_e;

    localparam int ACTIVE_IDX_W = 3;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/swerve_angle_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Scan from farthest to nearest so the candidate closest to ptr is written last.
    always_comb begin
        logic [IDX_W-1:0] j;
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/swerve_angle_scheduler.sv
// Time-shares one angle_to_pwm engine among NUM_WHEELS steering requesters.
// Optional macro SWERVE_SCHED_DEADBAND_EN completes near-target requests without an engine move.
module swerve_angle_scheduler
    import swerve_sched_pkg::*;
#(
    parameter int NUM_WHEELS     = 4,
    parameter int ANGLE_W        = 12,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEADBAND       = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_WHEELS-1:0]         req,
    input  logic [NUM_WHEELS*ANGLE_W-1:0] req_angle,
    input  logic [NUM_WHEELS*ANGLE_W-1:0] enc_angle,
    output logic [ANGLE_W-1:0]            target_angle,
    output logic [ANGLE_W-1:0]            current_angle,
    output logic                          angle_update,
    output logic                          abort_angle,
    input  logic                          angle_done,
    input  logic                          startup_fail,
    output logic [NUM_WHEELS-1:0]         wheel_done,
    output logic [NUM_WHEELS-1:0]         wheel_fail,
    output logic                          busy,
    output logic [ACTIVE_IDX_W-1:0]       active_idx
);

    localparam int IDX_W   = idx_width(NUM_WHEELS);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
`ifdef SWERVE_SCHED_DEADBAND_EN
    localparam bit DEADBAND_EN = 1'b1;
`else
    localparam bit DEADBAND_EN = 1'b0;
`endif

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ANGLE_W-1:0] target_q, target_d;
    logic [ANGLE_W-1:0] current_q, current_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ANGLE_W-1:0]    req_arr [NUM_WHEELS];
    logic [ANGLE_W-1:0]    enc_arr [NUM_WHEELS];
    logic [NUM_WHEELS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic [ANGLE_W-1:0]    enc_sel;
    logic [ANGLE_W-1:0]    fwd_dist, rev_dist, near_dist;
    logic                  in_deadband;
    logic [IDX_W-1:0]      next_ptr;
    logic [NUM_WHEELS-1:0] wheel_mask;

    always_comb begin
        for (int i = 0; i < NUM_WHEELS; i++) begin
            req_arr[i] = req_angle[i*ANGLE_W +: ANGLE_W];
            enc_arr[i] = enc_angle[i*ANGLE_W +: ANGLE_W];
        end
    end

    rr_arbiter #(
        .N     (NUM_WHEELS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign enc_sel    = enc_arr[idx_q];
    assign next_ptr   = (idx_q == IDX_W'(NUM_WHEELS - 1)) ? '0 : idx_q + IDX_W'(1);
    assign wheel_mask = NUM_WHEELS'(1) << idx_q;

    // Shortest circular distance between target and live encoder angle.
    always_comb begin
        fwd_dist    = target_q - enc_sel;
        rev_dist    = enc_sel - target_q;
        near_dist   = (fwd_dist <= rev_dist) ? fwd_dist : rev_dist;
        in_deadband = DEADBAND_EN && (32'(near_dist) <= 32'(DEADBAND));
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        target_d     = target_q;
        current_d    = current_q;
        cnt_d        = cnt_q;
        angle_update = 1'b0;
        abort_angle  = 1'b0;
        wheel_done   = '0;
        wheel_fail   = '0;

        if (state_q != IDLE) begin
            current_d = enc_sel;
        end

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    idx_d     = grant_idx;
                    target_d  = req_arr[grant_idx];
                    current_d = enc_arr[grant_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (in_deadband) begin
                    state_d = FINISH;
                end else begin
                    angle_update = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (angle_done) begin
                    state_d = FINISH;
                end else if (startup_fail) begin
                    abort_angle = 1'b1;
                    wheel_fail  = wheel_mask;
                    cnt_d       = '0;
                    state_d     = SETTLE;
                end else if (!req[idx_q]) begin
                    abort_angle = 1'b1;
                    cnt_d       = '0;
                    state_d     = SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_angle = 1'b1;
                    wheel_fail  = wheel_mask;
                    cnt_d       = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            FINISH: begin
                wheel_done = wheel_mask;
                ptr_d      = next_ptr;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset drops the grant silently; the engine is reset on its own.
        if (reset) begin
            angle_update = 1'b0;
            abort_angle  = 1'b0;
            wheel_done   = '0;
            wheel_fail   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            target_q  <= '0;
            current_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            target_q  <= target_d;
            current_q <= current_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_angle  = target_q;
    assign current_angle = current_q;
    assign busy          = (state_q != IDLE);
    assign active_idx    = ACTIVE_IDX_W'(idx_q);

endmodule
